ir_frame_tx: RTL and testbench

- Downstream consumer of the IR carrier clock stage. Takes the carrier level it produces and emits a modulated NEC-format IR frame.
- Frame layout: address byte, inverted address, command byte, inverted command. Bytes are sent LSB first.
- All frame timing is counted in carrier periods, so the block tracks whatever carrier rate the clock stage delivers.
- Out_IR drives the IR LED.

---
 rtl/ir_frame_tx.sv | 151 +++++++++++++++
 tb/tb_ir_frame_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_frame_tx.sv
// NEC-format IR frame transmitter. All segment timing is counted in carrier
// periods; the burst output gates the incoming carrier during mark segments.
module ir_frame_tx #(
    parameter int unsigned LEAD_MARK_CYC  = 342,
    parameter int unsigned LEAD_SPACE_CYC = 171,
    parameter int unsigned BIT_MARK_CYC   = 21,
    parameter int unsigned ZERO_SPACE_CYC = 21,
    parameter int unsigned ONE_SPACE_CYC  = 64,
    parameter int unsigned GAP_CYC        = 1520,
    parameter int unsigned CNT_W          = 12
) (
    input  logic       In_Clock,
    input  logic       In_Reset,
    input  logic       In_Carrier,
    input  logic       In_Valid,
    input  logic [7:0] In_Address,
    input  logic [7:0] In_Command,
    output logic       Out_Ready,
    output logic       Out_IR,
    output logic       Out_Busy,
    output logic       Out_Done
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitEdge,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        idx_q, idx_d;
    logic [31:0]       frame_q, frame_d;
    logic              carrier_q;
    logic              ir_q;
    logic              done_q, done_d;

    logic              tick;
    logic              mark;
    logic              counting;
    logic              seg_end;
    logic [CNT_W-1:0]  seg_last;

    assign tick     = In_Carrier & ~carrier_q;
    assign mark     = (state_q == StLeadMark) || (state_q == StBitMark) ||
                      (state_q == StStopMark);
    assign counting = (state_q != StIdle) && (state_q != StWaitEdge);

    // Count value of the final tick of the current segment.
    always_comb begin
        seg_last = '0;
        unique case (state_q)
            StLeadMark:  seg_last = CNT_W'(LEAD_MARK_CYC - 1);
            StLeadSpace: seg_last = CNT_W'(LEAD_SPACE_CYC - 1);
            StBitMark:   seg_last = CNT_W'(BIT_MARK_CYC - 1);
            StBitSpace:  seg_last = frame_q[idx_q] ? CNT_W'(ONE_SPACE_CYC - 1)
                                                   : CNT_W'(ZERO_SPACE_CYC - 1);
            StStopMark:  seg_last = CNT_W'(BIT_MARK_CYC - 1);
            StGap:       seg_last = CNT_W'(GAP_CYC - 1);
            default:     seg_last = '0;
        endcase
    end

    assign seg_end = counting && tick && (cnt_q == seg_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        done_d  = 1'b0;

        if (counting && tick) begin
            cnt_d = seg_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (In_Valid) begin
                    frame_d = {~In_Command, In_Command, ~In_Address, In_Address};
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StWaitEdge;
                end
            end
            StWaitEdge: begin
                if (tick) begin
                    cnt_d   = '0;
                    state_d = StLeadMark;
                end
            end
            StLeadMark: if (seg_end) state_d = StLeadSpace;
            StLeadSpace: begin
                if (seg_end) begin
                    idx_d   = '0;
                    state_d = StBitMark;
                end
            end
            StBitMark: if (seg_end) state_d = StBitSpace;
            StBitSpace: begin
                if (seg_end) begin
                    if (idx_q == 5'd31) begin
                        state_d = StStopMark;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StBitMark;
                    end
                end
            end
            StStopMark: begin
                if (seg_end) begin
                    done_d  = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: if (seg_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge In_Clock) begin
        if (In_Reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            carrier_q <= 1'b0;
            ir_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            carrier_q <= In_Carrier;
            ir_q      <= mark & In_Carrier;
            done_q    <= done_d;
        end
    end

    assign Out_Ready = (state_q == StIdle);
    assign Out_Busy  = (state_q != StIdle);
    assign Out_IR    = ir_q;
    assign Out_Done  = done_q;

endmodule

// File: tb/tb_ir_frame_tx.sv
// Self-checking bench for ir_frame_tx: a segment-queue model checked every cycle,
// plus burst/silence measurements pinned against hand-computed figures.
module tb_ir_frame_tx;

    localparam int LEAD_MARK  = 342;
    localparam int LEAD_SPACE = 171;
    localparam int BIT_MARK   = 21;
    localparam int ZERO_SPACE = 21;
    localparam int ONE_SPACE  = 64;
    localparam int GAP        = 1520;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] cmd = 8'h00;
    logic       ready, ir, busy, done;

    ir_frame_tx dut (
        .In_Clock   (clk),
        .In_Reset   (rst),
        .In_Carrier (car),
        .In_Valid   (valid),
        .In_Address (addr),
        .In_Command (cmd),
        .Out_Ready  (ready),
        .Out_IR     (ir),
        .Out_Busy   (busy),
        .Out_Done   (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Carrier generator: changes just after the clock edge, like a registered source.
    int  car_half = 10;
    int  car_cnt = 0;
    bit  car_en = 1'b1;
    initial forever begin
        @(posedge clk);
        #1;
        if (car_en) begin
            if (car_cnt >= car_half - 1) begin
                car_cnt = 0;
                car = ~car;
            end else begin
                car_cnt++;
            end
        end
    end

    bit scramble = 1'b0;
    initial forever begin
        @(negedge clk);
        if (scramble) cmd = 8'($urandom);
    end

    typedef struct {
        bit mk;
        int len;
        bit stop;
    } seg_t;

    seg_t q[$];
    bit   m_live = 1'b0, m_idle = 1'b1, m_wait = 1'b0, m_carq = 1'b0;
    bit   m_ir = 1'b0, m_done = 1'b0;
    int   m_cnt = 0;

    int   bursts[$];
    int   sils[$];
    int   done_cnt = 0;
    bit   prev_ir = 1'b0, in_burst = 1'b0;
    int   hi_run = 0, low_run = 0, cur_pulses = 0;

    function automatic void build(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] f;
        f = {~c, c, ~a, a};
        q.delete();
        q.push_back('{1'b1, LEAD_MARK, 1'b0});
        q.push_back('{1'b0, LEAD_SPACE, 1'b0});
        for (int i = 0; i < 32; i++) begin
            q.push_back('{1'b1, BIT_MARK, 1'b0});
            q.push_back('{1'b0, f[i] ? ONE_SPACE : ZERO_SPACE, 1'b0});
        end
        q.push_back('{1'b1, BIT_MARK, 1'b1});
        q.push_back('{1'b0, GAP, 1'b0});
    endfunction

    // Model update on each edge, then compare and measure 2 ns later.
    initial forever begin
        bit s_rst, s_car, s_val, tick;
        logic [7:0] s_a, s_c;
        @(posedge clk);
        s_rst = rst; s_car = car; s_val = valid; s_a = addr; s_c = cmd;
        if (s_rst) begin
            m_live = 1'b1; m_idle = 1'b1; m_wait = 1'b0; q.delete();
            m_cnt = 0; m_carq = 1'b0; m_ir = 1'b0; m_done = 1'b0;
        end else if (m_live) begin
            tick = s_car && !m_carq;
            m_ir = (!m_idle && !m_wait && q.size() > 0) ? (q[0].mk && s_car) : 1'b0;
            m_done = 1'b0;
            if (m_idle) begin
                if (s_val) begin
                    build(s_a, s_c);
                    m_idle = 1'b0;
                    m_wait = 1'b1;
                end
            end else if (m_wait) begin
                if (tick) begin
                    m_wait = 1'b0;
                    m_cnt = 0;
                end
            end else if (tick) begin
                m_cnt++;
                if (m_cnt == q[0].len) begin
                    m_done = q[0].stop;
                    q.delete(0);
                    m_cnt = 0;
                    if (q.size() == 0) m_idle = 1'b1;
                end
            end
            m_carq = s_car;
        end
        #2;
        if (m_live) begin
            chk("ir", 32'(ir), 32'(m_ir));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("ready", 32'(ready), 32'(m_idle));
            chk("done", 32'(done), 32'(m_done));
        end
        if (done === 1'b1) done_cnt++;
        // Burst monitor: pulses of 2+ clocks counted; a low run over 8 clocks ends a burst.
        if (ir === 1'b1) begin
            if (!prev_ir) begin
                if (!in_burst) begin
                    if (bursts.size() > 0) sils.push_back(low_run);
                    in_burst = 1'b1;
                    cur_pulses = 0;
                end
                hi_run = 0;
            end
            hi_run++;
            low_run = 0;
        end else begin
            if (prev_ir && hi_run >= 2) cur_pulses++;
            low_run++;
            if (in_burst && low_run == 9) begin
                bursts.push_back(cur_pulses);
                in_burst = 1'b0;
            end
        end
        prev_ir = (ir === 1'b1);
    end

    task automatic wait_for(input int which, input int limit, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < limit && !hit; k++) begin
            @(negedge clk);
            unique case (which)
                0: hit = (done === 1'b1);
                1: hit = (ready === 1'b1);
                2: hit = (ir === 1'b1);
                default: hit = (bursts.size() >= 3 && !in_burst);
            endcase
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout %s: condition not reached within %0d cycles", name, limit);
        end
    endtask

    task automatic clear_monitor();
        bursts.delete();
        sils.delete();
        in_burst = 1'b0;
    endtask

    initial begin
        int car_k, ir_k;
        bit pc;
        // Reset held for three edges with a 10/10 carrier.
        repeat (3) @(negedge clk);
        chk("rst_ir", 32'(ir), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(ready), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_ready", 32'(ready), 1);

        // Frame 1: addr 0x01, cmd 0x80; valid then held with a changing command.
        car_half = 3;
        repeat (20) @(negedge clk);
        clear_monitor();
        done_cnt = 0;
        addr = 8'h01;
        cmd = 8'h80;
        valid = 1'b1;
        @(negedge clk);
        chk("acc_busy", 32'(busy), 1);
        chk("acc_ready", 32'(ready), 0);
        scramble = 1'b1;
        wait_for(0, 30000, "frame1_done");
        wait_for(1, 12000, "frame1_ready");
        @(negedge clk);
        chk("reaccept_ready", 32'(ready), 0);
        chk("reaccept_busy", 32'(busy), 1);
        scramble = 1'b0;
        valid = 1'b0;
        chk("f1_bursts", 32'(bursts.size()), 34);
        chk("f1_lead", 32'(bursts[0]), 342);
        chk("f1_bit0", 32'(bursts[1]), 21);
        chk("f1_stop", 32'(bursts[33]), 21);
        chk("f1_lead_space", 32'(sils[0]), 6 * 171);
        chk("f1_bit0_space", 32'(sils[1]), 6 * 64);
        chk("f1_bit1_space", 32'(sils[2]), 6 * 21);
        chk("f1_bit16_space", 32'(sils[17]), 6 * 21);
        chk("f1_bit23_space", 32'(sils[24]), 6 * 64);
        chk("f1_bit31_space", 32'(sils[32]), 6 * 21);
        chk("f1_done_cycles", 32'(done_cnt), 1);

        // Reset about 100 ticks into the second frame's leader.
        wait_for(2, 200, "frame2_ir");
        chk("gap_silence", 32'(sils[33]), 6 * 1520 + 6);
        repeat (597) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        chk("midrst_ir", 32'(ir), 0);
        chk("midrst_ready", 32'(ready), 1);
        chk("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 0);

        // Frame 3 with a 500-clock carrier stall in bit1's space.
        clear_monitor();
        addr = 8'hA5;
        cmd = 8'h3C;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_for(3, 20000, "frame3_bit1");
        car_en = 1'b0;
        repeat (500) @(negedge clk);
        chk("stall_ir", 32'(ir), 0);
        chk("stall_busy", 32'(busy), 1);
        car_en = 1'b1;
        wait_for(0, 30000, "frame3_done");
        wait_for(1, 12000, "frame3_ready");
        chk("f3_bursts", 32'(bursts.size()), 34);
        chk("f3_lead", 32'(bursts[0]), 342);
        chk("f3_stop", 32'(bursts[33]), 21);
        chk("f3_stalled_space", 32'(sils[2]), 6 * 21 + 500);
        chk("f3_bit2_space", 32'(sils[3]), 6 * 64);
        chk("f3_done_cycles", 32'(done_cnt), 1);

        // Alignment: accept while the carrier is high, measure edge distance.
        rst = 1'b1;
        car_half = 10;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (car && car_cnt == 4) break;
        end
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        car_k = -1;
        ir_k = -1;
        pc = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #2;
            if (car && !pc && car_k < 0) car_k = k;
            if (ir === 1'b1 && ir_k < 0) ir_k = k;
            pc = car;
        end
        chk("align_first_ir", 32'(ir_k - car_k), 2);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
